// File: rtl/axi4_lite_pkg.sv
// Shared constants, FSM state types and slicing helpers for the AXI4-Lite address router.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  // A single-slave build still needs a 1-bit select to keep the ports legal.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int                              SLAVE_NUM       = 4,
  parameter int                              ADDR_WIDTH      = 32,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_BASE_ADDR = '0,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_ADDR_MASK = '0,
  localparam int                             SEL_W           = sel_width(SLAVE_NUM)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SEL_W-1:0]      sel,
  output logic                  miss
);

  logic [SLAVE_NUM-1:0] hit;

  for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_hit
    localparam logic [ADDR_WIDTH-1:0] BASE = SLAVE_BASE_ADDR[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
    localparam logic [ADDR_WIDTH-1:0] MASK = SLAVE_ADDR_MASK[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
    assign hit[i] = ((addr & MASK) == (BASE & MASK));
  end

  // Scanning from the top down lets lower indices overwrite higher ones on overlap.
  always_comb begin
    sel  = '0;
    miss = 1'b1;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel  = SEL_W'(i);
        miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_addr_router.sv
// Single-master to N-slave AXI4-Lite router with independent read/write FSMs and internal DECERR.
module axi4_lite_addr_router
  import axi4_lite_pkg::*;
#(
  parameter int                              SLAVE_NUM       = 4,
  parameter int                              ADDR_WIDTH      = 32,
  parameter int                              DATA_WIDTH      = 32,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_BASE_ADDR =
    {32'h0000_2000, 32'h0000_1000, 32'h0000_0100, 32'h0000_0000},
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_ADDR_MASK =
    {32'hFFFF_F000, 32'hFFFF_FFFF, 32'hFFFF_FF00, 32'hFFFF_FF00}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           s_awaddr,
  input  logic                            s_awvalid,
  output logic                            s_awready,
  input  logic [DATA_WIDTH-1:0]           s_wdata,
  input  logic [DATA_WIDTH/8-1:0]         s_wstrb,
  input  logic                            s_wvalid,
  output logic                            s_wready,
  output logic [1:0]                      s_bresp,
  output logic                            s_bvalid,
  input  logic                            s_bready,
  input  logic [ADDR_WIDTH-1:0]           s_araddr,
  input  logic                            s_arvalid,
  output logic                            s_arready,
  output logic [DATA_WIDTH-1:0]           s_rdata,
  output logic [1:0]                      s_rresp,
  output logic                            s_rvalid,
  input  logic                            s_rready,
  output logic [ADDR_WIDTH-1:0]           m_awaddr,
  output logic [DATA_WIDTH-1:0]           m_wdata,
  output logic [DATA_WIDTH/8-1:0]         m_wstrb,
  output logic [ADDR_WIDTH-1:0]           m_araddr,
  output logic [SLAVE_NUM-1:0]            m_awvalid,
  output logic [SLAVE_NUM-1:0]            m_wvalid,
  output logic [SLAVE_NUM-1:0]            m_bready,
  output logic [SLAVE_NUM-1:0]            m_arvalid,
  output logic [SLAVE_NUM-1:0]            m_rready,
  input  logic [SLAVE_NUM-1:0]            m_awready,
  input  logic [SLAVE_NUM-1:0]            m_wready,
  input  logic [SLAVE_NUM-1:0]            m_bvalid,
  input  logic [SLAVE_NUM-1:0]            m_arready,
  input  logic [SLAVE_NUM-1:0]            m_rvalid,
  input  logic [SLAVE_NUM*2-1:0]          m_bresp,
  input  logic [SLAVE_NUM*2-1:0]          m_rresp,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0] m_rdata
);

  localparam int SEL_W = sel_width(SLAVE_NUM);

  logic [SEL_W-1:0] aw_sel, ar_sel, w_sel, r_sel;
  logic             aw_miss, ar_miss, w_miss, r_miss;
  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;

  logic [1:0]            bresp_arr [SLAVE_NUM];
  logic [1:0]            rresp_arr [SLAVE_NUM];
  logic [DATA_WIDTH-1:0] rdata_arr [SLAVE_NUM];

  for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_unpack
    assign bresp_arr[i] = m_bresp[slice_lsb(i, 2) +: 2];
    assign rresp_arr[i] = m_rresp[slice_lsb(i, 2) +: 2];
    assign rdata_arr[i] = m_rdata[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
  end

  axi4_lite_addr_decode #(
    .SLAVE_NUM      (SLAVE_NUM),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .SLAVE_BASE_ADDR(SLAVE_BASE_ADDR),
    .SLAVE_ADDR_MASK(SLAVE_ADDR_MASK)
  ) u_aw_decode (
    .addr(s_awaddr),
    .sel (aw_sel),
    .miss(aw_miss)
  );

  axi4_lite_addr_decode #(
    .SLAVE_NUM      (SLAVE_NUM),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .SLAVE_BASE_ADDR(SLAVE_BASE_ADDR),
    .SLAVE_ADDR_MASK(SLAVE_ADDR_MASK)
  ) u_ar_decode (
    .addr(s_araddr),
    .sel (ar_sel),
    .miss(ar_miss)
  );

  assign m_awaddr = s_awaddr;
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_araddr = s_araddr;

  // The selection is captured only while idle, so it stays frozen until the response completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_sel   <= '0;
      w_miss  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && s_awvalid) begin
        w_sel  <= aw_sel;
        w_miss <= aw_miss;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_sel   <= '0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && s_arvalid) begin
        r_sel  <= ar_sel;
        r_miss <= ar_miss;
      end
    end
  end

  always_comb begin
    w_next    = w_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    case (w_state)
      W_IDLE: begin
        if (s_awvalid) w_next = W_ADDR;
      end
      W_ADDR: begin
        if (w_miss) begin
          s_awready = 1'b1;
        end else begin
          m_awvalid[w_sel] = 1'b1;
          s_awready        = m_awready[w_sel];
        end
        if (s_awready) w_next = W_DATA;
      end
      W_DATA: begin
        if (w_miss) begin
          s_wready = 1'b1;
        end else begin
          m_wvalid[w_sel] = s_wvalid;
          s_wready        = m_wready[w_sel];
        end
        if (s_wvalid && s_wready) w_next = W_RESP;
      end
      W_RESP: begin
        if (w_miss) begin
          s_bvalid = 1'b1;
          s_bresp  = RESP_DECERR;
        end else begin
          s_bvalid        = m_bvalid[w_sel];
          s_bresp         = bresp_arr[w_sel];
          m_bready[w_sel] = s_bready;
        end
        if (s_bvalid && s_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next    = r_state;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rresp   = RESP_OKAY;
    s_rdata   = '0;
    m_arvalid = '0;
    m_rready  = '0;
    case (r_state)
      R_IDLE: begin
        if (s_arvalid) r_next = R_ADDR;
      end
      R_ADDR: begin
        if (r_miss) begin
          s_arready = 1'b1;
        end else begin
          m_arvalid[r_sel] = 1'b1;
          s_arready        = m_arready[r_sel];
        end
        if (s_arready) r_next = R_DATA;
      end
      R_DATA: begin
        if (r_miss) begin
          s_rvalid = 1'b1;
          s_rresp  = RESP_DECERR;
        end else begin
          s_rvalid        = m_rvalid[r_sel];
          s_rresp         = rresp_arr[r_sel];
          s_rdata         = rdata_arr[r_sel];
          m_rready[r_sel] = s_rready;
        end
        if (s_rvalid && s_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_addr_router.sv
// Directed, table-driven bench for axi4_lite_addr_router; the bench plays both master and slaves.
module tb_axi4_lite_addr_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [3:0]  m_wstrb;
  logic [3:0]  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [3:0]  m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [7:0]  m_bresp, m_rresp;
  logic [127:0] m_rdata;

  logic        ov_s_awready, ov_s_wready, ov_s_bvalid, ov_s_arready, ov_s_rvalid;
  logic [1:0]  ov_s_bresp, ov_s_rresp;
  logic [31:0] ov_s_rdata, ov_m_awaddr, ov_m_wdata, ov_m_araddr;
  logic [3:0]  ov_m_wstrb, ov_m_awvalid, ov_m_wvalid, ov_m_bready, ov_m_arvalid, ov_m_rready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  exp_sel;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  axi4_lite_addr_router dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_araddr(m_araddr),
    .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_rready(m_rready),
    .m_awready(m_awready), .m_wready(m_wready), .m_bvalid(m_bvalid),
    .m_arready(m_arready), .m_rvalid(m_rvalid),
    .m_bresp(m_bresp), .m_rresp(m_rresp), .m_rdata(m_rdata)
  );

  // Overlapping map: slaves 0 and 1 both cover address 0, slave 0 must win.
  axi4_lite_addr_router #(
    .SLAVE_BASE_ADDR({32'h0000_2000, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000}),
    .SLAVE_ADDR_MASK({32'hFFFF_F000, 32'hFFFF_FFFF, 32'hFFFF_FF00, 32'hFFFF_F000})
  ) dut_ov (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(ov_s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(ov_s_wready),
    .s_bresp(ov_s_bresp), .s_bvalid(ov_s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(ov_s_arready),
    .s_rdata(ov_s_rdata), .s_rresp(ov_s_rresp), .s_rvalid(ov_s_rvalid), .s_rready(s_rready),
    .m_awaddr(ov_m_awaddr), .m_wdata(ov_m_wdata), .m_wstrb(ov_m_wstrb), .m_araddr(ov_m_araddr),
    .m_awvalid(ov_m_awvalid), .m_wvalid(ov_m_wvalid), .m_bready(ov_m_bready),
    .m_arvalid(ov_m_arvalid), .m_rready(ov_m_rready),
    .m_awready(m_awready), .m_wready(m_wready), .m_bvalid(m_bvalid),
    .m_arready(m_arready), .m_rvalid(m_rvalid),
    .m_bresp(m_bresp), .m_rresp(m_rresp), .m_rdata(m_rdata)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Selected slave answers OKAY, every other slave answers SLVERR so a wrong pick shows up.
  function automatic logic [7:0] respVec(input logic [3:0] sel);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = sel[i] ? 2'b00 : 2'b10;
    return r;
  endfunction

  task automatic slaveDefaults();
    m_awready = '1;
    m_wready  = '1;
    m_arready = '1;
    m_bvalid  = '0;
    m_rvalid  = '0;
    m_bresp   = 8'hAA;
    m_rresp   = 8'hAA;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    slaveDefaults();
    if (v.is_write) begin
      s_awaddr = v.addr; s_awvalid = 1'b1;
      s_wdata = v.wdata; s_wstrb = v.strb; s_wvalid = 1'b1; s_bready = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("v%0d_aw_bubble_ready", idx), 64'(s_awready), 64'd0);
      checkOutput($sformatf("v%0d_aw_bubble_valid", idx), 64'(m_awvalid), 64'd0);
      stepCycle();
      @(negedge clk);
      checkOutput($sformatf("v%0d_m_awvalid", idx), 64'(m_awvalid), 64'(v.exp_sel));
      checkOutput($sformatf("v%0d_s_awready", idx), 64'(s_awready), 64'd1);
      checkOutput($sformatf("v%0d_m_awaddr", idx), 64'(m_awaddr), 64'(v.addr));
      stepCycle();
      s_awvalid = 1'b0; s_awaddr = 32'hFFFF_FFF0;
      @(negedge clk);
      checkOutput($sformatf("v%0d_m_wvalid", idx), 64'(m_wvalid), 64'(v.exp_sel));
      checkOutput($sformatf("v%0d_s_wready", idx), 64'(s_wready), 64'd1);
      checkOutput($sformatf("v%0d_m_wdata", idx), 64'(m_wdata), 64'(v.wdata));
      checkOutput($sformatf("v%0d_m_wstrb", idx), 64'(m_wstrb), 64'(v.strb));
      stepCycle();
      s_wvalid = 1'b0; m_bvalid = v.exp_sel; m_bresp = respVec(v.exp_sel); s_bready = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("v%0d_s_bvalid", idx), 64'(s_bvalid), 64'd1);
      checkOutput($sformatf("v%0d_s_bresp", idx), 64'(s_bresp), 64'(v.exp_resp));
      checkOutput($sformatf("v%0d_m_bready", idx), 64'(m_bready), 64'(v.exp_sel));
      stepCycle();
      m_bvalid = '0; s_bready = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("v%0d_s_bvalid_done", idx), 64'(s_bvalid), 64'd0);
    end else begin
      s_araddr = v.addr; s_arvalid = 1'b1; s_rready = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("v%0d_ar_bubble_ready", idx), 64'(s_arready), 64'd0);
      checkOutput($sformatf("v%0d_ar_bubble_valid", idx), 64'(m_arvalid), 64'd0);
      stepCycle();
      @(negedge clk);
      checkOutput($sformatf("v%0d_m_arvalid", idx), 64'(m_arvalid), 64'(v.exp_sel));
      checkOutput($sformatf("v%0d_s_arready", idx), 64'(s_arready), 64'd1);
      checkOutput($sformatf("v%0d_m_araddr", idx), 64'(m_araddr), 64'(v.addr));
      stepCycle();
      s_arvalid = 1'b0; s_araddr = 32'hFFFF_FFF0;
      m_rvalid = v.exp_sel; m_rresp = respVec(v.exp_sel); s_rready = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("v%0d_s_rvalid", idx), 64'(s_rvalid), 64'd1);
      checkOutput($sformatf("v%0d_s_rdata", idx), 64'(s_rdata), 64'(v.exp_rdata));
      checkOutput($sformatf("v%0d_s_rresp", idx), 64'(s_rresp), 64'(v.exp_resp));
      checkOutput($sformatf("v%0d_m_rready", idx), 64'(m_rready), 64'(v.exp_sel));
      stepCycle();
      m_rvalid = '0; s_rready = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("v%0d_s_rvalid_done", idx), 64'(s_rvalid), 64'd0);
    end
    stepCycle();
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    stepCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 4'b0010, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_3000, 32'h0,         4'h0, 4'b0000, 2'b11, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 4'b0100, 2'b00, 32'hC0DE_2222};
    vecs[3] = '{1'b1, 32'h0000_01FF, 32'h1234_5678, 4'h3, 4'b0010, 2'b00, 32'h0};
    vecs[4] = '{1'b1, 32'h0000_1001, 32'hCAFE_F00D, 4'hF, 4'b0000, 2'b11, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 4'b0001, 2'b00, 32'hC0DE_0000};
    vecs[6] = '{1'b0, 32'h0000_2000, 32'h0,         4'h0, 4'b1000, 2'b00, 32'hC0DE_3333};
    vecs[7] = '{1'b1, 32'h0000_0FFF, 32'h5555_AAAA, 4'hC, 4'b0000, 2'b11, 32'h0};
    vecs[8] = '{1'b1, 32'h0000_2ABC, 32'h0F0F_0F0F, 4'h1, 4'b1000, 2'b00, 32'h0};
    vecs[9] = '{1'b0, 32'h0000_01FC, 32'h0,         4'h0, 4'b0010, 2'b00, 32'hC0DE_1111};

    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    m_rdata = {32'hC0DE_3333, 32'hC0DE_2222, 32'hC0DE_1111, 32'hC0DE_0000};
    slaveDefaults();
    m_bvalid = '1;
    m_rvalid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_s_readys", {s_awready, s_wready, s_arready}, 64'd0);
    checkOutput("rst_s_valids", {s_bvalid, s_rvalid}, 64'd0);
    checkOutput("rst_s_resps", {s_bresp, s_rresp}, 64'd0);
    checkOutput("rst_s_rdata", 64'(s_rdata), 64'd0);
    checkOutput("rst_m_valids", {m_awvalid, m_wvalid, m_arvalid}, 64'd0);
    checkOutput("rst_m_readys", {m_bready, m_rready}, 64'd0);
    stepCycle();
    rst = 1'b0;
    slaveDefaults();
    stepCycle();

    for (int i = 0; i < 10; i++) applyStimulus(i, vecs[i]);

    // Concurrent write to slave 0 and read from slave 3.
    s_awaddr = 32'h0000_0010; s_awvalid = 1'b1; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_araddr = 32'h0000_2FFC; s_arvalid = 1'b1;
    stepCycle();
    @(negedge clk);
    checkOutput("cc_m_awvalid", 64'(m_awvalid), 64'b0001);
    checkOutput("cc_m_arvalid", 64'(m_arvalid), 64'b1000);
    stepCycle();
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    m_rvalid = 4'b1000; m_rresp = respVec(4'b1000); s_rready = 1'b1;
    @(negedge clk);
    checkOutput("cc_m_wvalid", 64'(m_wvalid), 64'b0001);
    checkOutput("cc_s_rvalid", 64'(s_rvalid), 64'd1);
    checkOutput("cc_s_rdata", 64'(s_rdata), 64'hC0DE_3333);
    checkOutput("cc_s_rresp", 64'(s_rresp), 64'd0);
    stepCycle();
    s_wvalid = 1'b0; m_rvalid = '0; s_rready = 1'b0;
    m_bvalid = 4'b0001; m_bresp = respVec(4'b0001); s_bready = 1'b1;
    @(negedge clk);
    checkOutput("cc_s_rvalid_done", 64'(s_rvalid), 64'd0);
    checkOutput("cc_s_bvalid", 64'(s_bvalid), 64'd1);
    checkOutput("cc_s_bresp", 64'(s_bresp), 64'd0);
    checkOutput("cc_m_bready", 64'(m_bready), 64'b0001);
    stepCycle();
    m_bvalid = '0; s_bready = 1'b0;
    @(negedge clk);
    checkOutput("cc_s_bvalid_done", 64'(s_bvalid), 64'd0);
    stepCycle();

    // Slave 1 stalls the data phase and the master stalls the response.
    slaveDefaults();
    s_awaddr = 32'h0000_0104; s_awvalid = 1'b1; s_wdata = 32'h600D_CAFE; s_wstrb = 4'hF; s_wvalid = 1'b1;
    stepCycle();
    stepCycle();
    s_awvalid = 1'b0; m_wready = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("st_s_wready_%0d", k), 64'(s_wready), 64'd0);
      checkOutput($sformatf("st_m_wvalid_%0d", k), 64'(m_wvalid), 64'b0010);
      stepCycle();
    end
    m_wready = '1;
    @(negedge clk);
    checkOutput("st_s_wready_go", 64'(s_wready), 64'd1);
    stepCycle();
    s_wvalid = 1'b0; m_bvalid = 4'b0010; m_bresp = respVec(4'b0010); s_bready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("st_s_bvalid_%0d", k), 64'(s_bvalid), 64'd1);
      checkOutput($sformatf("st_s_bresp_%0d", k), 64'(s_bresp), 64'd0);
      checkOutput($sformatf("st_m_bready_%0d", k), 64'(m_bready), 64'd0);
      stepCycle();
    end
    s_bready = 1'b1;
    @(negedge clk);
    checkOutput("st_m_bready_go", 64'(m_bready), 64'b0010);
    stepCycle();
    @(negedge clk);
    checkOutput("st_no_dup_bvalid", 64'(s_bvalid), 64'd0);
    checkOutput("st_no_dup_bready", 64'(m_bready), 64'd0);
    stepCycle();
    m_bvalid = '0; s_bready = 1'b0;

    // Overlapping map on the second instance, started from a clean reset.
    pulseReset();
    slaveDefaults();
    for (int k = 0; k < 2; k++) begin
      s_araddr = (k == 0) ? 32'h0000_0000 : 32'h0000_0080;
      s_arvalid = 1'b1;
      stepCycle();
      @(negedge clk);
      checkOutput($sformatf("ov_m_arvalid_%0d", k), 64'(ov_m_arvalid), 64'b0001);
      stepCycle();
      s_arvalid = 1'b0; m_rvalid = 4'b0001; m_rresp = respVec(4'b0001); s_rready = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("ov_s_rdata_%0d", k), 64'(ov_s_rdata), 64'hC0DE_0000);
      stepCycle();
      m_rvalid = '0; s_rready = 1'b0;
      stepCycle();
    end

    // Reset asserted while the write FSM waits in its data phase.
    slaveDefaults();
    s_awaddr = 32'h0000_0104; s_awvalid = 1'b1; s_wdata = 32'h1111_2222; s_wstrb = 4'hF; s_wvalid = 1'b1;
    stepCycle();
    stepCycle();
    s_awvalid = 1'b0; m_wready = '0;
    @(negedge clk);
    checkOutput("rm_in_wdata", 64'(m_wvalid), 64'b0010);
    rst = 1'b1;
    #1;
    checkOutput("rm_async_wvalid", 64'(m_wvalid), 64'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("rm_valids", {m_awvalid, m_wvalid, m_arvalid}, 64'd0);
    checkOutput("rm_s_ready_valid", {s_awready, s_wready, s_bvalid, s_rvalid}, 64'd0);
    stepCycle();
    rst = 1'b0; s_wvalid = 1'b0;
    slaveDefaults();
    @(negedge clk);
    checkOutput("rm_no_bvalid", 64'(s_bvalid), 64'd0);
    stepCycle();
    applyStimulus(100, '{1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 4'hF, 4'b0010, 2'b00, 32'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
